// File: rtl/and_gate_checker.sv
// and_gate_checker
// Response monitor for a two-input AND gate. Each accepted {a,b} stimulus
// vector travels through a LAT-deep pipeline and is compared against the
// gate's y output when it reaches the head. Vectors and mismatches are
// counted with saturating counters, and truth-table coverage is collected.
// A pass/fail verdict is given once the run has drained.
//
// Optional feature macro: AND_CHECK_FIRST_ERR_EN
//   When defined, first_err_idx / first_err_vec / first_err_vld capture the
//   first mismatch after start. When undefined those ports do not exist.
//
// Handshake: a vector is taken on every rising edge where in_valid is high
// and the checker is in RUN with no start pulse. There is no back-pressure,
// so the monitor can never stall the stimulus stream.
module and_gate_checker #(
   parameter int unsigned LAT   = 0,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       cov,
   output logic [1:0]       state_dbg
`ifdef AND_CHECK_FIRST_ERR_EN
   ,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [2:0]       first_err_vec,
   output logic             first_err_vld
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // DRAIN lasts exactly LAT cycles; the counter counts down to zero.
   localparam logic [2:0] DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [2:0]       drain_q, drain_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [3:0]       cov_q, cov_d;

   logic accept;
   logic head_vld, head_a, head_b;
   logic mismatch;

   // A start pulse wins over everything, so a vector coincident with it is dropped.
   assign accept = (state_q == S_RUN) && in_valid && !start;

   generate
      if (LAT == 0) begin : g_nopipe
         // No latency: the check looks at the current-cycle vector directly.
         assign head_vld = accept;
         assign head_a   = a;
         assign head_b   = b;
      end else begin : g_pipe
         logic [LAT-1:0] pipe_vld_q;
         logic [LAT-1:0] pipe_a_q;
         logic [LAT-1:0] pipe_b_q;

         // Latency shift register carrying {valid, a, b}; start flushes it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_vld_q <= '0;
               pipe_a_q   <= '0;
               pipe_b_q   <= '0;
            end else if (start) begin
               pipe_vld_q <= '0;
               pipe_a_q   <= '0;
               pipe_b_q   <= '0;
            end else begin
               pipe_vld_q[0] <= accept;
               pipe_a_q[0]   <= a;
               pipe_b_q[0]   <= b;
               for (int i = 1; i < int'(LAT); i++) begin
                  pipe_vld_q[i] <= pipe_vld_q[i-1];
                  pipe_a_q[i]   <= pipe_a_q[i-1];
                  pipe_b_q[i]   <= pipe_b_q[i-1];
               end
            end
         end

         assign head_vld = pipe_vld_q[LAT-1];
         assign head_a   = pipe_a_q[LAT-1];
         assign head_b   = pipe_b_q[LAT-1];
      end
   endgenerate

   assign mismatch = head_vld && (y != (head_a & head_b));

   // FSM state and drain counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         drain_q <= 3'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Next-state logic: start restarts from any state, stop only acts in RUN.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      if (start) begin
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               if (stop) begin
                  if (LAT == 0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_DRAIN;
                     drain_d = DRAIN_INIT;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_q == 3'd0) begin
                  state_d = S_DONE;
               end else begin
                  drain_d = drain_q - 3'd1;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // Counter and coverage update for the vector at the pipeline head.
   always_comb begin
      vec_cnt_d = vec_cnt_q;
      err_cnt_d = err_cnt_q;
      cov_d     = cov_q;
      if (start) begin
         vec_cnt_d = '0;
         err_cnt_d = '0;
         cov_d     = 4'h0;
      end else if (head_vld) begin
         if (vec_cnt_q != '1) begin
            vec_cnt_d = vec_cnt_q + CNT_ONE;
         end
         cov_d[{head_a, head_b}] = 1'b1;
         if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
         end
      end
   end

   // Result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_cnt_q <= '0;
         err_cnt_q <= '0;
         cov_q     <= 4'h0;
      end else begin
         vec_cnt_q <= vec_cnt_d;
         err_cnt_q <= err_cnt_d;
         cov_q     <= cov_d;
      end
   end

`ifdef AND_CHECK_FIRST_ERR_EN
   logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
   logic [2:0]       fe_vec_q, fe_vec_d;
   logic             fe_vld_q, fe_vld_d;

   // Capture the first mismatch after start; hold until the next start.
   always_comb begin
      fe_idx_d = fe_idx_q;
      fe_vec_d = fe_vec_q;
      fe_vld_d = fe_vld_q;
      if (start) begin
         fe_idx_d = '0;
         fe_vec_d = 3'b000;
         fe_vld_d = 1'b0;
      end else if (mismatch && !fe_vld_q) begin
         fe_idx_d = vec_cnt_q;
         fe_vec_d = {head_a, head_b, y};
         fe_vld_d = 1'b1;
      end
   end

   // First-error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fe_idx_q <= '0;
         fe_vec_q <= 3'b000;
         fe_vld_q <= 1'b0;
      end else begin
         fe_idx_q <= fe_idx_d;
         fe_vec_q <= fe_vec_d;
         fe_vld_q <= fe_vld_d;
      end
   end

   assign first_err_idx = fe_idx_q;
   assign first_err_vec = fe_vec_q;
   assign first_err_vld = fe_vld_q;
`endif

   assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign pass      = done && (err_cnt_q == '0) && (cov_q == 4'hF);
   assign vec_cnt   = vec_cnt_q;
   assign err_cnt   = err_cnt_q;
   assign cov       = cov_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_and_gate_checker.sv
// Bench for and_gate_checker. Three instances share the stimulus:
//   u_l0 : LAT=0, CNT_W=16, y driven directly by the bench
//   u_l3 : LAT=3, CNT_W=16, y from a 3-cycle delayed correct gate model
//   u_c2 : LAT=0, CNT_W=2,  y driven directly by the bench
module tb_and_gate_checker;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic start = 1'b0, stop = 1'b0, in_valid = 1'b0;
   logic a_i = 1'b0, b_i = 1'b0, y_drive = 1'b0;
   logic [2:0] hist = 3'b000;
   logic y3;

   // Delayed correct gate for the LAT=3 instance: y at edge t+3 equals a&b of edge t.
   always @(posedge clk) hist <= {hist[1:0], a_i & b_i};
   assign y3 = hist[2];

   logic busy0, done0, pass0, busy3, done3, pass3, busyc, donec, passc;
   logic [15:0] vec0, err0, vec3, err3;
   logic [1:0]  vecc, errc;
   logic [3:0]  cov0, cov3, covc;
   logic [1:0]  st0, st3, stc;
`ifdef AND_CHECK_FIRST_ERR_EN
   logic [15:0] fidx0, fidx3;
   logic [1:0]  fidxc;
   logic [2:0]  fvec0, fvec3, fvecc;
   logic        fvld0, fvld3, fvldc;
`endif

   and_gate_checker #(.LAT(0), .CNT_W(16)) u_l0 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .a(a_i), .b(b_i), .y(y_drive), .busy(busy0), .done(done0), .pass(pass0),
      .vec_cnt(vec0), .err_cnt(err0), .cov(cov0), .state_dbg(st0)
`ifdef AND_CHECK_FIRST_ERR_EN
      , .first_err_idx(fidx0), .first_err_vec(fvec0), .first_err_vld(fvld0)
`endif
   );

   and_gate_checker #(.LAT(3), .CNT_W(16)) u_l3 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .a(a_i), .b(b_i), .y(y3), .busy(busy3), .done(done3), .pass(pass3),
      .vec_cnt(vec3), .err_cnt(err3), .cov(cov3), .state_dbg(st3)
`ifdef AND_CHECK_FIRST_ERR_EN
      , .first_err_idx(fidx3), .first_err_vec(fvec3), .first_err_vld(fvld3)
`endif
   );

   and_gate_checker #(.LAT(0), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
      .a(a_i), .b(b_i), .y(y_drive), .busy(busyc), .done(donec), .pass(passc),
      .vec_cnt(vecc), .err_cnt(errc), .cov(covc), .state_dbg(stc)
`ifdef AND_CHECK_FIRST_ERR_EN
      , .first_err_idx(fidxc), .first_err_vec(fvecc), .first_err_vld(fvldc)
`endif
   );

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_pass  = 0;
   logic [2:0] exp_q[$];   // accepted vectors {a,b,y} for the LAT=0 instance

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic av, input logic bv,
                        input logic yv, input logic sp);
      in_valid = iv;
      a_i      = av;
      b_i      = bv;
      y_drive  = yv;
      stop     = sp;
   endtask

   task automatic do_start(input logic with_stop);
      drive(1'b0, 1'b0, 1'b0, 1'b0, with_stop);
      start = 1'b1;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
      chk("start_busy", 32'(busy0), 32'd1);
      chk("start_done", 32'(done0), 32'd0);
      chk("start_vec",  32'(vec0),  32'd0);
   endtask

   // Random round checked against the accepted-vector list.
   task automatic rand_round(input int n, input int fault_pct, input logic with_stop);
      logic iv, av, bv, yv;
      int   e;
      int   first_e;
      logic [3:0] c;
      exp_q.delete();
      do_start(with_stop);
      for (int i = 0; i < n; i++) begin
         iv = 1'($urandom_range(0, 1));
         av = 1'($urandom_range(0, 1));
         bv = 1'($urandom_range(0, 1));
         yv = (av & bv) ^ ($urandom_range(0, 99) < fault_pct);
         drive(iv, av, bv, yv, (i == n - 1));
         if (iv) exp_q.push_back({av, bv, yv});
         cyc();
         chk("rnd_vec_live", 32'(vec0), 32'(exp_q.size()));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc();
      e = 0;
      c = 4'h0;
      first_e = -1;
      foreach (exp_q[k]) begin
         c[{exp_q[k][2], exp_q[k][1]}] = 1'b1;
         if (exp_q[k][0] != (exp_q[k][2] & exp_q[k][1])) begin
            if (first_e < 0) first_e = k;
            e++;
         end
      end
      chk("rnd_done0", 32'(done0), 32'd1);
      chk("rnd_err0",  32'(err0),  32'(e));
      chk("rnd_cov0",  32'(cov0),  32'(c));
      chk("rnd_pass0", 32'(pass0), 32'((e == 0) && (c == 4'hF)));
      chk("rnd_done3", 32'(done3), 32'd1);
      chk("rnd_vec3",  32'(vec3),  32'(exp_q.size()));
      chk("rnd_err3",  32'(err3),  32'd0);
      chk("rnd_cov3",  32'(cov3),  32'(c));
      chk("rnd_vecc",  32'(vecc),  32'((exp_q.size() > 3) ? 3 : exp_q.size()));
      chk("rnd_errc",  32'(errc),  32'((e > 3) ? 3 : e));
`ifdef AND_CHECK_FIRST_ERR_EN
      chk("rnd_fvld0", 32'(fvld0), 32'(first_e >= 0));
      if (first_e >= 0) begin
         chk("rnd_fidx0", 32'(fidx0), 32'(first_e));
         chk("rnd_fvec0", 32'(fvec0), 32'(exp_q[first_e]));
      end
`endif
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        iv, a, b, yflip, stp;
      logic [15:0] exp_vec, exp_err;
      logic [3:0]  exp_cov;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // rows 0..3: correct gate; rows 4..7: y forced 1 on vector 01
      tbl[0] = '{1, 0, 0, 0, 0, 16'd1, 16'd0, 4'h1};
      tbl[1] = '{1, 0, 1, 0, 0, 16'd2, 16'd0, 4'h3};
      tbl[2] = '{1, 1, 0, 0, 0, 16'd3, 16'd0, 4'h7};
      tbl[3] = '{1, 1, 1, 0, 1, 16'd4, 16'd0, 4'hF};
      tbl[4] = '{1, 0, 0, 0, 0, 16'd1, 16'd0, 4'h1};
      tbl[5] = '{1, 0, 1, 1, 0, 16'd2, 16'd1, 4'h3};
      tbl[6] = '{1, 1, 0, 0, 0, 16'd3, 16'd1, 4'h7};
      tbl[7] = '{1, 1, 1, 0, 1, 16'd4, 16'd1, 4'hF};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_pass", 32'(pass0), 32'd0);
      rst_n = 1'b1;
      cyc();
      chk("rst_vec",   32'(vec0), 32'd0);
      chk("rst_err",   32'(err0), 32'd0);
      chk("rst_cov",   32'(cov0), 32'd0);
      chk("rst_state", 32'(st0),  32'd0);

      // LAT=0 truth table, then again with a fault on 01
      for (int i = 0; i < 8; i++) begin
         if (i % 4 == 0) do_start(1'b0);
         drive(tbl[i].iv, tbl[i].a, tbl[i].b, (tbl[i].a & tbl[i].b) | tbl[i].yflip, tbl[i].stp);
         cyc();
         chk("tbl_vec", 32'(vec0), 32'(tbl[i].exp_vec));
         chk("tbl_err", 32'(err0), 32'(tbl[i].exp_err));
         chk("tbl_cov", 32'(cov0), 32'(tbl[i].exp_cov));
         if (tbl[i].stp) begin
            chk("tbl_done", 32'(done0), 32'd1);
            chk("tbl_pass", 32'(pass0), 32'(tbl[i].exp_err == 16'd0));
`ifdef AND_CHECK_FIRST_ERR_EN
            chk("tbl_fvld", 32'(fvld0), 32'(tbl[i].exp_err != 16'd0));
            if (tbl[i].exp_err != 16'd0) begin
               chk("tbl_fidx", 32'(fidx0), 32'd1);
               chk("tbl_fvec", 32'(fvec0), 32'b011);
            end
`endif
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // stop and vectors in DONE are ignored
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("done_stop_ign", 32'(done0), 32'd1);
      chk("done_vec_ign",  32'(vec0),  32'd4);
      chk("done_err_ign",  32'(err0),  32'd1);

      // LAT=3: stop on the last vector, busy holds for 3 cycles
      do_start(1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, k[1], k[0], k[1] & k[0], (k == 3));
         cyc();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("lat3_busy", 32'(busy3), 32'd1);
         chk("lat3_ndone", 32'(done3), 32'd0);
         cyc();
      end
      chk("lat3_busy_fall", 32'(busy3), 32'd0);
      chk("lat3_done", 32'(done3), 32'd1);
      chk("lat3_vec",  32'(vec3),  32'd4);
      chk("lat3_err",  32'(err3),  32'd0);
      chk("lat3_cov",  32'(cov3),  32'hF);
      chk("lat3_pass", 32'(pass3), 32'd1);

      // partial coverage: only 00 and 11
      do_start(1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("part_done", 32'(done0), 32'd1);
      chk("part_err",  32'(err0),  32'd0);
      chk("part_cov",  32'(cov0),  32'h9);
      chk("part_pass", 32'(pass0), 32'd0);

      // reset during DRAIN with 2 vectors in flight
      do_start(1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("drain_busy", 32'(busy3), 32'd1);
      chk("drain_state", 32'(st3), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy",  32'(busy3), 32'd0);
      chk("mrst_done",  32'(done3), 32'd0);
      chk("mrst_pass",  32'(pass3), 32'd0);
      chk("mrst_vec",   32'(vec3),  32'd0);
      chk("mrst_cov",   32'(cov3),  32'd0);
      chk("mrst_state", 32'(st3),   32'd0);
      cyc();
      rst_n = 1'b1;
      // in_valid in IDLE is ignored
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) cyc();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_vecc", 32'(vecc), 32'd0);
      chk("idle_errc", 32'(errc), 32'd0);
      chk("idle_vec0", 32'(vec0), 32'd0);
      do_start(1'b0);
      chk("post_rst_vec3", 32'(vec3), 32'd0);
      repeat (4) cyc();
      chk("post_rst_vec3_late", 32'(vec3), 32'd0);

      // CNT_W=2 saturation: 5 vectors 11 with y stuck at 0
      do_start(1'b0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, (k == 4));
         cyc();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sat_vecc",  32'(vecc),  32'd3);
      chk("sat_errc",  32'(errc),  32'd3);
      chk("sat_donec", 32'(donec), 32'd1);
      chk("sat_vec0",  32'(vec0),  32'd5);
      chk("sat_err0",  32'(err0),  32'd5);

      // randomized rounds; second one starts with start and stop together
      rand_round(60, 0, 1'b0);
      rand_round(80, 15, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
